// File: rtl/fsm_sequential_divider.sv
`timescale 1ns/1ps
// fsm_sequential_divider
//   Signed two's-complement restoring divider, one quotient bit per clock.
//   Divides a 2*LENGTH-bit dividend by a LENGTH-bit divisor and returns a
//   LENGTH-bit quotient (truncated toward zero) and a LENGTH-bit remainder
//   (same sign as the dividend). Handshake and flags match the sequential
//   multiplier so both can share an arithmetic unit.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start        request; sampled only in IDLE or READY
//   dividend     signed dividend (2*LENGTH bits), sampled on accept
//   divisor      signed divisor (LENGTH bits), sampled on accept
//   quotient     signed quotient, wrapped to LENGTH bits on overflow
//   remainder    signed remainder
//   Computing    high while in COMPUTING or FIX
//   Ready        one-cycle pulse, result valid
//   Negative     true quotient is negative
//   overflow     true quotient does not fit LENGTH bits, or divide by zero
//   div_by_zero  divisor was zero
module fsm_sequential_divider #(
  parameter int LENGTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2*LENGTH-1:0]   dividend,
  input  logic [LENGTH-1:0]     divisor,
  output logic [LENGTH-1:0]     quotient,
  output logic [LENGTH-1:0]     remainder,
  output logic                  Computing,
  output logic                  Ready,
  output logic                  Negative,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int DW = 2 * LENGTH;
  localparam int CW = $clog2(2 * LENGTH + 1);

  // Largest quotient magnitudes representable in LENGTH signed bits.
  localparam logic [DW-1:0] QPOS_MAX = DW'((1 << (LENGTH - 1)) - 1);
  localparam logic [DW-1:0] QNEG_MAX = DW'(1 << (LENGTH - 1));

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTING = 2'd1,
    FIX       = 2'd2,
    READY     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     dvd_q, dvd_d;     // dividend magnitude, consumed MSB first
  logic [LENGTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [LENGTH-1:0] part_q, part_d;   // partial remainder (always < |divisor|)
  logic [DW-1:0]     qmag_q, qmag_d;   // quotient magnitude
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sgnq_q, sgnq_d;
  logic              sgnr_q, sgnr_d;
  logic              zero_q, zero_d;
  logic [LENGTH-1:0] quot_q, quot_d;
  logic [LENGTH-1:0] rem_q, rem_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              dbz_q, dbz_d;
  logic [LENGTH:0]   part_sh;          // partial remainder after shift-in

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      qmag_q  <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      qmag_q  <= qmag_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    qmag_d  = qmag_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    part_sh = {part_q, dvd_q[DW-1]};

    unique case (state_q)
      IDLE, READY: begin
        if (start) begin
          // Magnitudes are unsigned, so the most negative operand still fits.
          dvd_d   = dividend[DW-1] ? -dividend : dividend;
          dvs_d   = divisor[LENGTH-1] ? -divisor : divisor;
          sgnq_d  = dividend[DW-1] ^ divisor[LENGTH-1];
          sgnr_d  = dividend[DW-1];
          zero_d  = (divisor == '0);
          part_d  = '0;
          qmag_d  = '0;
          cnt_d   = '0;
          quot_d  = '0;
          rem_d   = '0;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = COMPUTING;
        end else begin
          state_d = IDLE;
        end
      end

      COMPUTING: begin
        if (zero_q) begin
          quot_d  = '0;
          rem_d   = '0;
          neg_d   = 1'b0;
          ovf_d   = 1'b1;
          dbz_d   = 1'b1;
          state_d = READY;
        end else begin
          dvd_d = {dvd_q[DW-2:0], 1'b0};
          if (part_sh >= {1'b0, dvs_q}) begin
            part_d = LENGTH'(part_sh - {1'b0, dvs_q});
            qmag_d = {qmag_q[DW-2:0], 1'b1};
          end else begin
            part_d = part_sh[LENGTH-1:0];
            qmag_d = {qmag_q[DW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) state_d = FIX;
        end
      end

      FIX: begin
        quot_d  = sgnq_q ? -qmag_q[LENGTH-1:0] : qmag_q[LENGTH-1:0];
        rem_d   = sgnr_q ? -part_q : part_q;
        neg_d   = sgnq_q && (qmag_q != '0);
        ovf_d   = sgnq_q ? (qmag_q > QNEG_MAX) : (qmag_q > QPOS_MAX);
        state_d = READY;
      end

      default: state_d = IDLE;
    endcase
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign Negative    = neg_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign Ready       = (state_q == READY);
  assign Computing   = (state_q == COMPUTING) || (state_q == FIX);

endmodule
